// File: rtl/marquee_pkg.sv
// Shared types for the marquee scroll controller: command opcodes and FSM states.
package marquee_pkg;

  localparam int ROT_W = 4;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_RUN   = 2'b01,
    OP_PAUSE = 2'b10,
    OP_STEP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_STEP
  } state_e;

endpackage

// File: rtl/marquee_ctrl_tick_gen.sv
// Step-rate divider: counts 0..DIV-1 while enabled, o_step is high combinationally in the
// last count; no backpressure, synchronous clear overrides enable.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));
  assign o_step = i_en && w_last;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/marquee_ctrl.sv
// Marquee scroll controller: steps a barrel-shift amount at STEP_HZ, outputs registered (1 cycle
// from command or step event); cmd_ready drops only during the single STEP cycle.
module marquee_ctrl
  import marquee_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 4,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic               i_cmd_dir,
  input  logic [ROT_W-1:0]   i_cmd_loops,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_busy,
  output logic               o_tick,
  output logic               o_done
);

  localparam int DIV = CLK_HZ / STEP_HZ;

  state_e             r_state;
  state_e             r_ret;
  logic               r_dir;
  logic [ROT_W-1:0]   r_loops;
  logic [ROT_W-1:0]   r_rot;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_busy;
  logic               r_ready;
  logic               r_tick;
  logic               r_done;

  cmd_op_e            w_op;
  logic               w_acc;
  logic               w_step;
  logic               w_apply;
  logic               w_wrap;
  logic               w_fin;
  logic               w_clr;
  logic [SHIFT_W-1:0] w_run_shift;
  logic [ROT_W-1:0]   w_rot_inc;

  function automatic logic [SHIFT_W-1:0] nudge(input logic [SHIFT_W-1:0] s, input logic dn);
    return dn ? s - SHIFT_W'(1) : s + SHIFT_W'(1);
  endfunction

  assign w_op        = cmd_op_e'(i_cmd_op);
  assign w_acc       = i_cmd_valid && r_ready;
  // Any command landing on a step event wins; the step is simply lost.
  assign w_apply     = w_step && !w_acc;
  assign w_run_shift = nudge(r_shift, r_dir);
  assign w_wrap      = (w_run_shift == '0);
  assign w_rot_inc   = r_rot + ROT_W'(1);
  assign w_fin       = w_apply && w_wrap && (r_loops != '0) && (w_rot_inc == r_loops);
  assign w_clr       = w_fin ||
                       (w_acc && ((w_op == OP_STOP) ||
                                  ((w_op == OP_RUN) && (r_state != ST_PAUSE))));

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .nrst   (nrst),
    .i_en   (r_state == ST_RUN),
    .i_clr  (w_clr),
    .o_step (w_step)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_IDLE;
      r_dir   <= 1'b0;
      r_loops <= '0;
      r_rot   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            case (w_op)
              OP_RUN: begin
                r_dir   <= i_cmd_dir;
                r_loops <= i_cmd_loops;
                r_rot   <= '0;
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
              end
              OP_STEP: begin
                r_shift <= nudge(r_shift, i_cmd_dir);
                r_tick  <= 1'b1;
                r_ret   <= ST_IDLE;
                r_state <= ST_STEP;
                r_ready <= 1'b0;
              end
              OP_STOP: begin
                r_shift <= '0;
                r_rot   <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            case (w_op)
              OP_STOP: begin
                r_shift <= '0;
                r_rot   <= '0;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
              OP_RUN: begin
                r_dir   <= i_cmd_dir;
                r_loops <= i_cmd_loops;
                r_rot   <= '0;
              end
              OP_PAUSE: r_state <= ST_PAUSE;
              default: ;
            endcase
          end else if (w_apply) begin
            r_shift <= w_run_shift;
            r_tick  <= 1'b1;
            if (w_wrap) begin
              r_rot <= w_rot_inc;
            end
            if (w_fin) begin
              r_rot   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (w_acc) begin
            case (w_op)
              OP_STOP: begin
                r_shift <= '0;
                r_rot   <= '0;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
              OP_RUN: r_state <= ST_RUN;
              OP_STEP: begin
                r_shift <= nudge(r_shift, i_cmd_dir);
                r_tick  <= 1'b1;
                r_ret   <= ST_PAUSE;
                r_state <= ST_STEP;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_STEP: begin
          r_state <= r_ret;
          r_ready <= 1'b1;
          r_busy  <= (r_ret == ST_PAUSE);
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_shift     = r_shift;
  assign o_busy      = r_busy;
  assign o_tick      = r_tick;
  assign o_done      = r_done;

endmodule

// File: tb/tb_marquee_ctrl.sv
// Directed bench for marquee_ctrl at DIV=4, SHIFT_W=3; outputs sampled 1ns after each rising edge.
module tb_marquee_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic       i_cmd_dir;
  logic [3:0] i_cmd_loops;
  logic [2:0] o_shift;
  logic       o_busy;
  logic       o_tick;
  logic       o_done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] STOP  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] STEP  = 2'b11;

  marquee_ctrl #(
    .CLK_HZ  (40),
    .STEP_HZ (10),
    .SHIFT_W (3)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_dir   (i_cmd_dir),
    .i_cmd_loops (i_cmd_loops),
    .o_shift     (o_shift),
    .o_busy      (o_busy),
    .o_tick      (o_tick),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic dir, input logic [3:0] loops);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_dir   = dir;
    i_cmd_loops = loops;
    cyc();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst        = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_op    = STOP;
    i_cmd_dir   = 1'b0;
    i_cmd_loops = 4'd0;
    #22;
    chk("rst_shift", 32'(o_shift), 0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_tick",  32'(o_tick),  0);
    chk("rst_done",  32'(o_done),  0);
    nrst = 1'b1;
    #1;
    chk("rst_ready", 32'(o_cmd_ready), 1);

    // Endless left scroll: ticks every 4 cycles after acceptance
    send(RUN, 1'b0, 4'd0);
    chk("run_busy", 32'(o_busy), 1);
    chk("run_tick0", 32'(o_tick), 0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("run_tick",  32'(o_tick),  32'((i % 4) == 0));
      chk("run_shift", 32'(o_shift), 32'(i / 4));
      chk("run_done",  32'(o_done),  0);
    end
    send(STOP, 1'b0, 4'd0);
    chk("stop_shift", 32'(o_shift), 0);
    chk("stop_busy",  32'(o_busy),  0);

    // One right rotation then auto-stop with done
    send(RUN, 1'b1, 4'd1);
    for (int i = 1; i <= 32; i++) begin
      cyc();
      chk("loop_tick",  32'(o_tick),  32'((i % 4) == 0));
      chk("loop_shift", 32'(o_shift), 32'((8 - i / 4) % 8));
      chk("loop_done",  32'(o_done),  32'(i == 32));
      chk("loop_busy",  32'(o_busy),  32'(i != 32));
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("idle_tick",  32'(o_tick),  0);
      chk("idle_done",  32'(o_done),  0);
      chk("idle_shift", 32'(o_shift), 0);
    end

    // Pause two cycles after a tick, resume keeps phase and latched dir
    send(RUN, 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) cyc();
    chk("p_tick", 32'(o_tick), 1);
    chk("p_shift", 32'(o_shift), 1);
    cyc();
    send(PAUSE, 1'b0, 4'd0);
    chk("p_busy", 32'(o_busy), 1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("p_hold_tick", 32'(o_tick), 0);
      chk("p_hold_shift", 32'(o_shift), 1);
    end
    send(RUN, 1'b1, 4'd5);
    chk("res_tick0", 32'(o_tick), 0);
    cyc();
    chk("res_tick1", 32'(o_tick), 0);
    cyc();
    chk("res_tick2", 32'(o_tick), 1);
    chk("res_shift", 32'(o_shift), 2);
    send(STOP, 1'b0, 4'd0);
    chk("res_stop_shift", 32'(o_shift), 0);

    // Single steps in IDLE: 0 -> 7 (right) then 7 -> 0 (left)
    send(STEP, 1'b1, 4'd0);
    chk("st1_shift", 32'(o_shift), 7);
    chk("st1_tick", 32'(o_tick), 1);
    chk("st1_ready", 32'(o_cmd_ready), 0);
    cyc();
    chk("st1_ready_back", 32'(o_cmd_ready), 1);
    send(STEP, 1'b0, 4'd0);
    chk("st2_shift", 32'(o_shift), 0);
    chk("st2_tick", 32'(o_tick), 1);
    chk("st2_done", 32'(o_done), 0);
    chk("st2_ready", 32'(o_cmd_ready), 0);
    chk("st2_busy", 32'(o_busy), 0);
    cyc();
    chk("st2_ready_back", 32'(o_cmd_ready), 1);
    chk("st2_tick_off", 32'(o_tick), 0);
    chk("st2_shift_hold", 32'(o_shift), 0);

    // STOP coincident with the step event that would take shift 5 -> 6
    send(RUN, 1'b0, 4'd0);
    for (int i = 1; i <= 23; i++) cyc();
    chk("cs_shift5", 32'(o_shift), 5);
    send(STOP, 1'b0, 4'd0);
    chk("cs_tick", 32'(o_tick), 0);
    chk("cs_shift", 32'(o_shift), 0);
    chk("cs_busy", 32'(o_busy), 0);
    chk("cs_done", 32'(o_done), 0);
    cyc();
    chk("cs_tick_after", 32'(o_tick), 0);

    // Asynchronous reset mid-run at shift 3
    send(RUN, 1'b0, 4'd2);
    for (int i = 1; i <= 12; i++) cyc();
    chk("ar_shift3", 32'(o_shift), 3);
    nrst = 1'b0;
    #2;
    chk("ar_shift", 32'(o_shift), 0);
    chk("ar_busy", 32'(o_busy), 0);
    chk("ar_done", 32'(o_done), 0);
    #2;
    nrst = 1'b1;
    send(RUN, 1'b0, 4'd0);
    chk("ar_run_busy", 32'(o_busy), 1);
    for (int i = 1; i <= 4; i++) cyc();
    chk("ar_tick", 32'(o_tick), 1);
    chk("ar_shift1", 32'(o_shift), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/marquee_ctrl.md
MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter STEP_HZ, default 4, shift step rate in Hz; DIV = CLK_HZ/STEP_HZ SHALL be >= 2.
REQ-003 Parameter SHIFT_W, default 3, width of the shift amount driven to the display barrel shifter.
REQ-004 clk  input  1  clock.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  input  2  00 STOP, 01 RUN, 10 PAUSE, 11 STEP.
REQ-009 cmd_dir  input  1  0 = increment shift (left), 1 = decrement (right); sampled on RUN and STEP.
REQ-010 cmd_loops  input  4  full rotations before auto-stop; 0 = endless; sampled on RUN.
REQ-011 shift  output  SHIFT_W  current shift amount to the barrel shifter.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 tick  output  1  one-cycle pulse on every applied step.
REQ-014 done  output  1  one-cycle pulse on loop-count completion.

Function
REQ-015 FSM states IDLE, RUN, PAUSE, STEP; SHALL leave reset in IDLE.
REQ-016 cmd_ready SHALL be 1 in IDLE, RUN, PAUSE and 0 in STEP.
REQ-017 Divider counts 0..DIV-1 only in RUN; the internal step event fires when count == DIV-1, giving a period of exactly DIV cycles.
REQ-018 On a step event, shift SHALL change by +1 or -1 modulo 2^SHIFT_W per the latched dir, registered, and tick SHALL pulse in the same cycle that shift updates.
REQ-019 A rotation completes when a step makes shift equal 0; the rotation counter (4 bits) SHALL then increment.
REQ-020 If latched loops != 0 and rotation count reaches loops, the FSM SHALL enter IDLE, done SHALL pulse for 1 cycle coincident with that tick, and shift SHALL hold 0.
REQ-021 RUN accepted from IDLE: latch dir/loops, clear divider and rotation count, shift unchanged, enter RUN; the first step occurs DIV cycles after acceptance.
REQ-022 RUN accepted in RUN: reload dir/loops, clear divider and rotation count, shift unchanged.
REQ-023 RUN accepted in PAUSE: resume with divider phase, rotation count and latched dir/loops preserved; cmd_dir/cmd_loops ignored.
REQ-024 PAUSE accepted in RUN: enter PAUSE, divider frozen; PAUSE in IDLE or PAUSE is a no-op.
REQ-025 STOP accepted in any state: enter IDLE, shift := 0, divider and rotation count cleared, no done.
REQ-026 STEP accepted in IDLE or PAUSE: enter STEP for one cycle, apply one step per cmd_dir with tick, return to the originating state; rotation counting and done do not apply; STEP in RUN is a no-op.
REQ-027 A command accepted in the same cycle as a divider step event SHALL take priority; that step is discarded (no tick, no shift change).
REQ-028 done and tick SHALL never be asserted in IDLE except on the exit cycle per REQ-020 or in the STEP cycle per REQ-026.

Reset
REQ-029 On nrst low, asynchronously: state IDLE, shift 0, divider 0, rotation count 0, latched dir 0, latched loops 0, tick 0, done 0, busy 0; cmd_ready is 1 once nrst is released.
REQ-030 Reset asserted mid-RUN SHALL abort without done; first command is accepted on the first rising edge after release.

Structure
REQ-031 Package marquee_pkg SHALL hold the cmd_op enum (STOP/RUN/PAUSE/STEP) and the state enum.
REQ-032 Divider SHALL be a sub-module tick_gen with enable, synchronous clear, and a step-event output, width $clog2(DIV).

Verification (CLK_HZ=40, STEP_HZ=10, DIV=4, SHIFT_W=3)
REQ-033 Reset, then RUN dir=0 loops=0 -> ticks at cycles 4, 8, 12 after acceptance; shift 1, 2, 3; busy=1.
REQ-034 RUN dir=1 loops=1 from shift 0 -> shift 7..0 over 8 ticks; done pulses with the tick that sets shift to 0; state IDLE, busy 0.
REQ-035 RUN, PAUSE 2 cycles after a tick, wait 20 cycles, RUN -> no ticks during pause; next tick 2 cycles after resume.
REQ-036 STEP dir=0 in IDLE from shift 7 -> shift 0 next cycle, tick 1, done 0, cmd_ready low for that one cycle, state back to IDLE.
REQ-037 STOP issued on the same cycle as a step event while shift=5 -> no tick, shift 0, IDLE, no done.
REQ-038 nrst pulsed low mid-RUN at shift=3 -> shift 0, busy 0, no done; RUN accepted on the first edge after release.
